// File: rtl/fifo_pkg.sv
// Shared constants, helpers and the access-kind encoding for the parametrised FIFO.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // One extra bit so the count can represent DEPTH itself, not just 0..DEPTH-1.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // Bit 0 = accepted write, bit 1 = accepted read.
  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_WR   = 2'b01,
    ACC_RD   = 2'b10,
    ACC_BOTH = 2'b11
  } access_e;

endpackage

// File: rtl/fifo_param_if.sv
// Producer/consumer handshake bundle for fifo_param; master drives requests, slave is the FIFO.
interface fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              almost_empty;
  logic              underflow;
  logic [CNT_W-1:0]  fifo_words;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  full, almost_full, overflow, data_out, empty, almost_empty, underflow, fifo_words
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output full, almost_full, overflow, data_out, empty, almost_empty, underflow, fifo_words
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, combinational read.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, sticky error flags, flush and
// a choice of registered or first-word-fall-through read data.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic         clk,
  input logic         rst,
  fifo_param_if.slave bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("fifo_param: DATA_W must be at least 1");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              is_full, is_empty;
  logic              wr_acc, rd_acc;
  access_e           access;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);
  assign wr_acc   = bus.wr_en && !is_full;
  assign rd_acc   = bus.rd_en && !is_empty;
  assign access   = access_e'({rd_acc, wr_acc});

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !bus.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Flush wins over any request in the same cycle but leaves the read register alone.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    dout_d      = dout_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        dout_d   = mem_rdata;
      end
      overflow_d  = overflow_q  | (bus.wr_en & is_full);
      underflow_d = underflow_q | (bus.rd_en & is_empty);
      case (access)
        ACC_WR:  count_d = count_q + CNT_W'(1);
        ACC_RD:  count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_q      <= dout_d;
    end
  end

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.fifo_words   = count_q;

  // In fall-through mode the head entry is shown directly from the array.
  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = mem_rdata;
  end else begin : g_std
    assign bus.data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Drives a standard-mode and a fall-through FIFO with identical stimulus and checks both
// against a queue-based reference model.
module tb_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) busA ();
  fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) busB ();

  fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit         ovf;
  bit         unf;
  logic [7:0] expDout;

  // Status packed as {full, almost_full, empty, almost_empty, overflow, underflow, words}.
  function automatic logic [9:0] expStat();
    int n;
    n = q.size();
    return {n == DEPTH, n >= AF, n == 0, n <= AE, ovf, unf, 4'(n)};
  endfunction

  function automatic logic [9:0] statA();
    return {busA.full, busA.almost_full, busA.empty, busA.almost_empty,
            busA.overflow, busA.underflow, busA.fifo_words};
  endfunction

  function automatic logic [9:0] statB();
    return {busB.full, busB.almost_full, busB.empty, busB.almost_empty,
            busB.overflow, busB.underflow, busB.fifo_words};
  endfunction

  task automatic clearInputs();
    busA.wr_en = 1'b0; busA.rd_en = 1'b0; busA.flush = 1'b0; busA.data_in = '0;
    busB.wr_en = 1'b0; busB.rd_en = 1'b0; busB.flush = 1'b0; busB.data_in = '0;
  endtask

  task automatic modelReset();
    q.delete();
    ovf = 1'b0;
    unf = 1'b0;
    expDout = 8'h00;
  endtask

  // One clock of stimulus applied to both FIFOs; the model advances on pre-edge occupancy.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
    bit wa;
    bit ra;
    busA.wr_en = w; busA.data_in = d; busA.rd_en = r; busA.flush = f;
    busB.wr_en = w; busB.data_in = d; busB.rd_en = r; busB.flush = f;
    @(posedge clk);
    if (f) begin
      q.delete();
      ovf = 1'b0;
      unf = 1'b0;
    end else begin
      wa = w && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      if (w && !wa) ovf = 1'b1;
      if (r && !ra) unf = 1'b1;
      if (ra) expDout = q.pop_front();
      if (wa) q.push_back(d);
    end
    #1;
    clearInputs();
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (statA() !== 10'b0011000000) begin
      fails++; $display("[TB] FAIL reset_statusA: got %b expected %b", statA(), 10'b0011000000);
    end
    tests++;
    if (statB() !== 10'b0011000000) begin
      fails++; $display("[TB] FAIL reset_statusB: got %b expected %b", statB(), 10'b0011000000);
    end
    tests++;
    if (busA.data_out !== 8'h00) begin
      fails++; $display("[TB] FAIL reset_dout: got %h expected 00", busA.data_out);
    end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      tests++;
      if (statA() !== expStat()) begin
        fails++; $display("[TB] FAIL fill_status[%0d]: got %b expected %b", i, statA(), expStat());
      end
      tests++;
      if (busA.almost_full !== (i >= 6)) begin
        fails++; $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", i, busA.almost_full, i >= 6);
      end
    end
    tests++;
    if (busA.full !== 1'b1 || busA.fifo_words !== 4'd8) begin
      fails++; $display("[TB] FAIL fill_full: got full=%b words=%0d expected full=1 words=8", busA.full, busA.fifo_words);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    tests++;
    if (busA.overflow !== 1'b1 || busA.fifo_words !== 4'd8) begin
      fails++; $display("[TB] FAIL fill_overflow: got ovf=%b words=%0d expected ovf=1 words=8", busA.overflow, busA.fifo_words);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      tests++;
      if (busA.data_out !== 8'(i + 1)) begin
        fails++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, busA.data_out, 8'(i + 1));
      end
      tests++;
      if (statA() !== expStat()) begin
        fails++; $display("[TB] FAIL drain_status[%0d]: got %b expected %b", i, statA(), expStat());
      end
      if (i < 7) begin
        tests++;
        if (busB.data_out !== 8'(i + 2)) begin
          fails++; $display("[TB] FAIL drain_fwft_head[%0d]: got %h expected %h", i, busB.data_out, 8'(i + 2));
        end
      end
      if (i == 5) begin
        tests++;
        if (busA.almost_empty !== 1'b1 || busA.fifo_words !== 4'd2) begin
          fails++; $display("[TB] FAIL drain_almost_empty: got ae=%b words=%0d expected ae=1 words=2", busA.almost_empty, busA.fifo_words);
        end
      end
    end
    tests++;
    if (busA.empty !== 1'b1) begin
      fails++; $display("[TB] FAIL drain_empty: got %b expected 1", busA.empty);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (busA.underflow !== 1'b1 || busA.data_out !== 8'h08) begin
      fails++; $display("[TB] FAIL drain_underflow: got unf=%b dout=%h expected unf=1 dout=08", busA.underflow, busA.data_out);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      tests++;
      if (busA.data_out !== 8'(8'h20 + i)) begin
        fails++; $display("[TB] FAIL wrap_prefill[%0d]: got %h expected %h", i, busA.data_out, 8'(8'h20 + i));
      end
    end
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
      tests++;
      if (busA.fifo_words !== 4'd1 || busA.data_out !== ((i == 0) ? 8'h0F : 8'(8'h10 + i - 1))) begin
        fails++; $display("[TB] FAIL wrap_simul[%0d]: got words=%0d dout=%h expected words=1 dout=%h",
                          i, busA.fifo_words, busA.data_out, (i == 0) ? 8'h0F : 8'(8'h10 + i - 1));
      end
    end
  endtask

  task automatic test_races();
    logic [7:0] first;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    first = 8'($urandom_range(0, 255));
    step(1'b1, first, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    tests++;
    if (busA.fifo_words !== 4'd7 || busA.overflow !== 1'b1 || busA.data_out !== first) begin
      fails++; $display("[TB] FAIL race_full: got words=%0d ovf=%b dout=%h expected words=7 ovf=1 dout=%h",
                        busA.fifo_words, busA.overflow, busA.data_out, first);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    tests++;
    if (busA.fifo_words !== 4'd1 || busA.underflow !== 1'b1 || busA.empty !== 1'b0 || busA.data_out !== first) begin
      fails++; $display("[TB] FAIL race_empty: got words=%0d unf=%b empty=%b dout=%h expected words=1 unf=1 empty=0 dout=%h",
                        busA.fifo_words, busA.underflow, busA.empty, busA.data_out, first);
    end
  endtask

  task automatic test_fwft();
    logic [7:0] heldA;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    heldA = expDout;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    tests++;
    if (busB.empty !== 1'b0 || busB.data_out !== 8'hA5) begin
      fails++; $display("[TB] FAIL fwft_show: got empty=%b dout=%h expected empty=0 dout=a5", busB.empty, busB.data_out);
    end
    tests++;
    if (busA.data_out !== heldA) begin
      fails++; $display("[TB] FAIL fwft_std_hold: got %h expected %h", busA.data_out, heldA);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (busB.empty !== 1'b1 || busA.data_out !== 8'hA5) begin
      fails++; $display("[TB] FAIL fwft_pop: got emptyB=%b doutA=%h expected emptyB=1 doutA=a5", busB.empty, busA.data_out);
    end
  endtask

  task automatic test_flush();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (busA.fifo_words !== 4'd4 || busA.overflow !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_setup: got words=%0d ovf=%b expected words=4 ovf=1", busA.fifo_words, busA.overflow);
    end
    step(1'b1, 8'h99, 1'b0, 1'b1);
    tests++;
    if (statA() !== 10'b0011000000 || busA.data_out !== 8'h33) begin
      fails++; $display("[TB] FAIL flush_clear: got stat=%b dout=%h expected stat=0011000000 dout=33", statA(), busA.data_out);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (busA.fifo_words !== 4'd0 || statB() !== expStat()) begin
      fails++; $display("[TB] FAIL flush_ignored_write: got words=%0d statB=%b expected words=0 statB=%b", busA.fifo_words, statB(), expStat());
    end
  endtask

  task automatic test_random();
    bit w, r, f;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      w = (i < 200) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
      r = (i < 200) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 70);
      f = ($urandom_range(0, 63) == 0);
      step(w, 8'($urandom_range(0, 255)), r, f);
      tests++;
      if (statA() !== expStat() || statB() !== expStat()) begin
        fails++; $display("[TB] FAIL rand_status[%0d]: got A=%b B=%b expected %b", i, statA(), statB(), expStat());
      end
      tests++;
      if (busA.data_out !== expDout) begin
        fails++; $display("[TB] FAIL rand_dout[%0d]: got %h expected %h", i, busA.data_out, expDout);
      end
      if (q.size() > 0) begin
        tests++;
        if (busB.data_out !== q[0]) begin
          fails++; $display("[TB] FAIL rand_fwft_head[%0d]: got %h expected %h", i, busB.data_out, q[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h48, 1'b0, 1'b0);
    step(1'b1, 8'h49, 1'b0, 1'b0);
    tests++;
    if (busA.overflow !== 1'b1 || busA.data_out !== 8'h40) begin
      fails++; $display("[TB] FAIL areset_setup: got ovf=%b dout=%h expected ovf=1 dout=40", busA.overflow, busA.data_out);
    end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (statA() !== 10'b0011000000 || busA.data_out !== 8'h00) begin
      fails++; $display("[TB] FAIL areset_immediate: got stat=%b dout=%h expected stat=0011000000 dout=00", statA(), busA.data_out);
    end
    tests++;
    if (statB() !== 10'b0011000000) begin
      fails++; $display("[TB] FAIL areset_immediateB: got %b expected 0011000000", statB());
    end
    #1;
    rst = 1'b0;
    modelReset();
    step(1'b1, 8'h77, 1'b0, 1'b0);
    tests++;
    if (statA() !== expStat() || busB.data_out !== 8'h77) begin
      fails++; $display("[TB] FAIL areset_resume: got stat=%b doutB=%h expected stat=%b doutB=77", statA(), busB.data_out, expStat());
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_races();
    test_fwft();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that succeeds the fixed 8x8 FIFO. It is generalised in data width and depth. It adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, almost_full asserts when fifo_words >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when fifo_words <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of contents, count and error flags
wr_en  in  1  write request
data_in  in  DATA_W  write data
full  out  1  fifo_words == DEPTH
almost_full  out  1  fifo_words >= AF_LEVEL
overflow  out  1  sticky: a write was attempted while full
rd_en  in  1  read request (in FWFT mode, acknowledge/pop)
data_out  out  DATA_W  read data
empty  out  1  fifo_words == 0
almost_empty  out  1  fifo_words <= AE_LEVEL
underflow  out  1  sticky: a read was attempted while empty
fifo_words  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr, rd_ptr, fifo_words = 0; data_out = 0; overflow = underflow = 0.
  - Resulting outputs: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all contents immediately.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- All status flags are derived from the registered fifo_words, so they change only on clock edges.
- Write accept: wr_en && !full, evaluated on pre-edge state.
  - On accept, data_in is written to mem[wr_ptr] and wr_ptr increments.
  - Write while full: data is dropped, state is unchanged, overflow sets.
- Read accept: rd_en && !empty, evaluated on pre-edge state.
  - On accept, rd_ptr increments.
  - Read while empty: no state change, underflow sets.
- Simultaneous accepted write and read: fifo_words unchanged.
- Write when full is rejected even if a read is accepted in the same cycle (read proceeds, count drops by 1).
- Read when empty is rejected even if a write is accepted in the same cycle (count rises by 1).
- fifo_words: +1 on write-only accept, -1 on read-only accept, otherwise held.
- Standard mode (FWFT=0):
  - On an accepted read, data_out is registered with mem[rd_ptr] at that edge, so data is valid the cycle after rd_en.
  - data_out holds otherwise, including on rejected reads and on flush.
- FWFT mode (FWFT=1):
  - data_out continuously presents mem[rd_ptr] and is valid whenever empty = 0.
  - The first word is visible the cycle after its write edge; empty deasserts at that same edge.
  - rd_en pops the head word, and the next word appears after the edge.
  - data_out is undefined while empty.
- flush:
  - Has priority over wr_en/rd_en in the same cycle, which are ignored.
  - Clears pointers, fifo_words, overflow and underflow.
  - Does not clear data_out.
- Error flags stay set until rst or flush.

Decomposition:
- Shared package/header fifo_pkg holds:
  - a clog2 constant function;
  - derived constants ADDR_W = clog2(DEPTH) and CNT_W = ADDR_W+1;
  - parameter-legality checks (DEPTH power of two, threshold ranges) raised as elaboration errors.
- One sub-module, fifo_mem: a DEPTH x DATA_W register array with synchronous write and asynchronous read port.
- The FIFO control (pointers, count, flags, output register/FWFT mux) lives in fifo_param.

Test Plan:
- Reset/fill (DATA_W=8, DEPTH=8, FWFT=0): assert rst, then write 0x01..0x08 on consecutive cycles.
  - After the 6th write: almost_full=1.
  - After the 8th write: full=1, fifo_words=8.
  - A 9th write of 0xFF: overflow=1, fifo_words stays 8.
- Drain/order: from full, read 8 times.
  - data_out is 0x01..0x08, each one cycle after its rd_en.
  - almost_empty=1 at fifo_words=2; empty=1 after the last read.
  - An extra read sets underflow=1 and data_out holds 0x08.
- Wrap and simultaneous access: write 5, read 5, then write/read the same cycle for 12 cycles with data 0x10..0x1B.
  - fifo_words is constant and the data order is preserved across pointer wrap.
- Boundary races:
  - With full and wr_en+rd_en asserted: the read is accepted, the write is dropped, fifo_words becomes 7, overflow=1.
  - With empty and both asserted: the write is accepted, no read, fifo_words becomes 1.
- FWFT=1: write 0xA5 into the empty FIFO.
  - Next cycle: empty=0 and data_out=0xA5 with no rd_en.
  - rd_en pops it, and empty=1 after that edge.
- Flush/async reset:
  - With 4 words stored and overflow set, pulse flush together with wr_en: fifo_words=0, empty=1, overflow=0, and the write is ignored.
  - Assert rst between clock edges: outputs go to reset values immediately.
